result_stream: RTL and testbench
================================

RESULT_STREAM -- requirements
Module: result_stream

Interface
REQ-001 Parameter N, default 541, polynomial degree: number of result coefficients.
REQ-002 Parameter q, default 2048, coefficient modulus; coefficient width CW = clog2(q-1) = 11.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 end_op  input  1  level from multiplier control; rising edge means the result memory is complete.
REQ-006 addr_e  output  clog2(N-1)  result-memory read address.
REQ-007 en_e  output  1  result-memory read enable.
REQ-008 data_e  input  CW  read data, valid exactly one cycle after en_e is high.
REQ-009 m_axis_tdata  output  32  AXI4-Stream payload.
REQ-010 m_axis_tvalid  output  1  AXI4-Stream valid.
REQ-011 m_axis_tready  input  1  AXI4-Stream ready from downstream.
REQ-012 m_axis_tlast  output  1  high on the final beat only.
REQ-013 busy  output  1  high from trigger until the last beat is accepted.
REQ-014 done  output  1  one-cycle pulse in the cycle after the last handshake.

Function
REQ-015 FSM states: IDLE, STREAM, DONE.
- IDLE -> STREAM on end_op rising edge, detected against a registered copy.
- STREAM -> DONE when the beat with tlast is accepted.
- DONE -> IDLE after one cycle.
REQ-016 end_op held high does not retrigger; a new transfer requires end_op low then high again.
REQ-017 In STREAM, issue reads for addresses 0..N-1 in ascending order, each address exactly once.
REQ-018 Issue a read only if the free entries in the 2-entry output buffer exceed the number of reads in flight.
REQ-019 A beat transfers when m_axis_tvalid and m_axis_tready are both high.
REQ-020 While tvalid is high and tready is low, tdata, tvalid and tlast stay unchanged.
REQ-021 With tready held high, sustain one beat per cycle; first tvalid occurs 2 cycles after the trigger edge is sampled.
REQ-022 Beat format: coefficient zero-extended in tdata[CW-1:0]; tdata[31:CW] = 0.
REQ-023 tlast is high only on the beat carrying coefficient N-1.
REQ-024 Address counter stops at N-1; it never wraps during a transfer.
REQ-025 end_op edges during STREAM or DONE are ignored.
REQ-026 tvalid does not depend combinationally on tready.

Reset
REQ-027 While rst is low, asynchronously force the following, independent of clk:
- state = IDLE, buffer empty, in-flight count 0;
- addr_e = 0, en_e = 0, m_axis_tdata = 0, tvalid = 0, tlast = 0, busy = 0, done = 0;
- registered end_op = 0.
REQ-028 Reset asserted mid-transfer aborts the transfer; no partial resume after release.
REQ-029 If end_op is already high when rst releases, the block starts no transfer until end_op goes low and rises again.

Configuration
REQ-030 Macro RESULT_STREAM_PACK2_EN selects the packing mode.
- Defined: two coefficients per beat, index 2b in tdata[CW-1:0] and index 2b+1 in tdata[16+CW-1:16]; all other bits are 0.
- Defined: beats = ceil(N/2); for odd N, the final beat's upper field is 0.
- Defined: tlast is on the final beat.
- Undefined: REQ-022 behaviour applies, with N beats.

Verification
REQ-031 N=541, tready=1, end_op rises, memory[i]=i mod 2048 -> 541 beats on consecutive cycles; tdata = 0..540; tlast only on the beat with tdata=540; done pulses once.
REQ-032 N=7, tready toggled 1,0,0,1 repeatedly -> data sequence 0..6 unchanged, no beat lost or duplicated, tdata stable whenever tvalid=1 and tready=0.
REQ-033 end_op held high 2000 cycles after done -> no second transfer; drop end_op 1 cycle then raise it -> second identical 541-beat stream.
REQ-034 rst pulsed low at beat 100 -> all outputs 0 within the reset cycle; no beats after release until a new end_op edge.
REQ-035 RESULT_STREAM_PACK2_EN defined, N=7, memory = 1..7 -> 4 beats: 0x00020001, 0x00040003, 0x00060005, 0x00000007; tlast on beat 4.
REQ-036 memory[0]=2047, tready=0 for 50 cycles after the trigger -> tvalid high with tdata=0x000007FF held constant; at most 2 reads issued before the first handshake.

Source files
------------

// File: rtl/result_stream.sv
// Streams the N-coefficient result memory out over AXI4-Stream after end_op rises.
// Define RESULT_STREAM_PACK2_EN to pack two coefficients per 32-bit beat.
module result_stream #(
   parameter int N = 541,
   parameter int q = 2048,
   localparam int CW = $clog2(q - 1),
   localparam int AW = ($clog2(N - 1) > 0) ? $clog2(N - 1) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          end_op,
   output logic [AW-1:0] addr_e,
   output logic          en_e,
   input  logic [CW-1:0] data_e,
   output logic [31:0]   m_axis_tdata,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic          m_axis_tlast,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t      state;
   logic        end_op_q;
   logic        armed;
   logic        all_issued;
   logic        dv;
   logic        dv_last;
   logic        skid_v;
   logic [31:0] skid_d;
   logic        skid_l;
`ifdef RESULT_STREAM_PACK2_EN
   logic          half_v;
   logic [CW-1:0] half_d;
`endif

   logic        pop;
   logic        trigger;
   logic [1:0]  cnt;
   logic [2:0]  free;
   logic        push;
   logic [31:0] push_d;
   logic        push_l;

   // en_e is decoded combinationally so the read lands one cycle earlier;
   // with that latency a 2-entry buffer is enough for one beat per cycle.
   always_comb begin
      pop     = m_axis_tvalid & m_axis_tready;
      trigger = (state == IDLE) & end_op & ~end_op_q & armed;
      cnt     = 2'(m_axis_tvalid) + 2'(skid_v);
      free    = 3'd2 - {1'b0, cnt} + {2'b0, pop};
      en_e    = (state == STREAM) && !all_issued && (free > {2'b0, dv});
      push_d  = '0;
      push_l  = dv_last;
`ifdef RESULT_STREAM_PACK2_EN
      push = dv & (half_v | dv_last);
      if (half_v) begin
         push_d[CW-1:0]  = half_d;
         push_d[16 +: CW] = data_e;
      end else begin
         push_d[CW-1:0] = data_e;
      end
`else
      push = dv;
      push_d[CW-1:0] = data_e;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         end_op_q      <= 1'b0;
         armed         <= 1'b0;
         all_issued    <= 1'b0;
         dv            <= 1'b0;
         dv_last       <= 1'b0;
         addr_e        <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         skid_v        <= 1'b0;
         skid_d        <= '0;
         skid_l        <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef RESULT_STREAM_PACK2_EN
         half_v        <= 1'b0;
         half_d        <= '0;
`endif
      end else begin
         end_op_q <= end_op;
         // A level already high out of reset must fall before it can trigger.
         if (!end_op)
            armed <= 1'b1;
         done    <= 1'b0;
         dv      <= en_e;
         dv_last <= en_e && (addr_e == LAST_ADDR);

         case (state)
            IDLE: begin
               if (trigger) begin
                  state      <= STREAM;
                  busy       <= 1'b1;
                  addr_e     <= '0;
                  all_issued <= 1'b0;
`ifdef RESULT_STREAM_PACK2_EN
                  half_v     <= 1'b0;
`endif
               end
            end
            STREAM: begin
               if (en_e) begin
                  if (addr_e == LAST_ADDR)
                     all_issued <= 1'b1;
                  else
                     addr_e <= addr_e + AW'(1);
               end
               if (pop && m_axis_tlast) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

`ifdef RESULT_STREAM_PACK2_EN
         if (dv && !push) begin
            half_v <= 1'b1;
            half_d <= data_e;
         end else if (push) begin
            half_v <= 1'b0;
         end
`endif

         // Output register is the head of the buffer, skid is the second entry.
         if (!m_axis_tvalid || pop) begin
            if (skid_v) begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= skid_d;
               m_axis_tlast  <= skid_l;
               skid_v        <= push;
               if (push) begin
                  skid_d <= push_d;
                  skid_l <= push_l;
               end
            end else if (push) begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= push_d;
               m_axis_tlast  <= push_l;
            end else begin
               m_axis_tvalid <= 1'b0;
               m_axis_tlast  <= 1'b0;
            end
         end else if (push) begin
            skid_v <= 1'b1;
            skid_d <= push_d;
            skid_l <= push_l;
         end
      end
   end

endmodule

// File: tb/tb_result_stream.sv
// Directed bench for result_stream: two instances (N=541 and N=7) checked
// every cycle against a memory-driven beat model.
module tb_result_stream;

   localparam int NA = 541;
   localparam int NB = 7;
   localparam int CW = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0;

   logic          end_op_a = 1'b0, tready_a = 1'b1;
   logic          en_a, tvalid_a, tlast_a, busy_a, done_a;
   logic [9:0]    addr_a;
   logic [CW-1:0] data_a = '0;
   logic [31:0]   tdata_a;

   logic          end_op_b = 1'b0, tready_b = 1'b1;
   logic          en_b, tvalid_b, tlast_b, busy_b, done_b;
   logic [2:0]    addr_b;
   logic [CW-1:0] data_b = '0;
   logic [31:0]   tdata_b;

   logic [CW-1:0] mem_a [0:NA-1];
   logic [CW-1:0] mem_b [0:NB-1];

   result_stream #(.N(NA), .q(2048)) dut_a (
      .clk(clk), .rst(rst), .end_op(end_op_a), .addr_e(addr_a), .en_e(en_a),
      .data_e(data_a), .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a),
      .m_axis_tready(tready_a), .m_axis_tlast(tlast_a), .busy(busy_a), .done(done_a));

   result_stream #(.N(NB), .q(2048)) dut_b (
      .clk(clk), .rst(rst), .end_op(end_op_b), .addr_e(addr_b), .en_e(en_b),
      .data_e(data_b), .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b),
      .m_axis_tready(tready_b), .m_axis_tlast(tlast_b), .busy(busy_b), .done(done_b));

   always @(posedge clk) begin
      if (en_a) data_a <= mem_a[addr_a];
      if (en_b) data_b <= mem_b[addr_b];
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s actual=0x%08h expected=none", name, act);
   endtask

   // ---------------- model ----------------
   bit          active   [2];
   int          exp_idx  [2];
   int          rd_exp   [2];
   bit          stall    [2];
   logic [31:0] prev_d   [2];
   logic        prev_l   [2];
   bit          done_due [2];
   logic [31:0] first_d  [2];
   logic [31:0] last_d   [2];
   logic [31:0] beats_b  [0:3];

   function automatic int ncoef(input int i);
      return (i == 0) ? NA : NB;
   endfunction

   function automatic int nbeats(input int i);
`ifdef RESULT_STREAM_PACK2_EN
      return (ncoef(i) + 1) / 2;
`else
      return ncoef(i);
`endif
   endfunction

   function automatic logic [31:0] mem_at(input int i, input int idx);
      return (i == 0) ? 32'(mem_a[idx]) : 32'(mem_b[idx]);
   endfunction

   function automatic logic [31:0] exp_beat(input int i, input int k);
`ifdef RESULT_STREAM_PACK2_EN
      logic [31:0] r;
      r = mem_at(i, 2 * k);
      if (2 * k + 1 < ncoef(i)) r = r | (mem_at(i, 2 * k + 1) << 16);
      return r;
`else
      return mem_at(i, k);
`endif
   endfunction

   task automatic cmp_inst(input int i, input logic tv, input logic tr, input logic tl,
                           input logic [31:0] td, input logic en, input int addr, input logic dn);
      chk($sformatf("done_%0d", i), 32'(dn), 32'(done_due[i]));
      done_due[i] = 1'b0;
      if (stall[i]) begin
         chk($sformatf("hold_tvalid_%0d", i), 32'(tv), 32'd1);
         chk($sformatf("hold_tdata_%0d", i), td, prev_d[i]);
         chk($sformatf("hold_tlast_%0d", i), 32'(tl), 32'(prev_l[i]));
      end
      if (en) begin
         if (!active[i] || rd_exp[i] >= ncoef(i))
            flag($sformatf("extra_read_%0d", i), 32'(addr));
         else begin
            chk($sformatf("read_addr_%0d", i), 32'(addr), 32'(rd_exp[i]));
            rd_exp[i]++;
         end
      end
      if (tv && tr) begin
         if (!active[i])
            flag($sformatf("unexpected_beat_%0d", i), td);
         else begin
            chk($sformatf("tdata_%0d_beat%0d", i, exp_idx[i]), td, exp_beat(i, exp_idx[i]));
            chk($sformatf("tlast_%0d_beat%0d", i, exp_idx[i]), 32'(tl),
                32'(exp_idx[i] == nbeats(i) - 1));
            if (exp_idx[i] == 0) first_d[i] = td;
            if (i == 1 && exp_idx[i] < 4) beats_b[exp_idx[i]] = td;
            if (exp_idx[i] == nbeats(i) - 1) begin
               last_d[i]   = td;
               active[i]   = 1'b0;
               done_due[i] = 1'b1;
            end
            exp_idx[i]++;
         end
      end
      stall[i]  = tv && !tr;
      prev_d[i] = td;
      prev_l[i] = tl;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         cmp_inst(0, tvalid_a, tready_a, tlast_a, tdata_a, en_a, int'(addr_a), done_a);
         cmp_inst(1, tvalid_b, tready_b, tlast_b, tdata_b, en_b, int'(addr_b), done_b);
      end else begin
         for (int i = 0; i < 2; i++) begin
            stall[i]    = 1'b0;
            done_due[i] = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic start(input int i);
      active[i]  = 1'b1;
      exp_idx[i] = 0;
      rd_exp[i]  = 0;
      if (i == 0) end_op_a = 1'b1; else end_op_b = 1'b1;
   endtask

   task automatic wait_done(input int i, input int budget);
      int c = 0;
      while (((i == 0) ? done_a : done_b) !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (c >= budget) flag($sformatf("timeout_done_%0d", i), 32'(c));
   endtask

   task automatic check_zero_a(input string tag);
      chk({tag, "_ctl_a"}, 32'({addr_a, en_a, tvalid_a, tlast_a, busy_a, done_a}), 32'd0);
      chk({tag, "_tdata_a"}, tdata_a, 32'd0);
   endtask

   initial begin
      int cyc;
      int reads;
      bit seen;
      for (int i = 0; i < NA; i++) mem_a[i] = CW'(i);
      for (int i = 0; i < NB; i++) mem_b[i] = CW'(i);
      for (int i = 0; i < 2; i++) begin
         active[i] = 0; exp_idx[i] = 0; rd_exp[i] = 0; stall[i] = 0; done_due[i] = 0;
         first_d[i] = '0; last_d[i] = '0;
      end
      for (int i = 0; i < 4; i++) beats_b[i] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero_a("reset");
      chk("reset_ctl_b", 32'({addr_b, en_b, tvalid_b, tlast_b, busy_b, done_b}), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);

      // Full-rate stream, latency and length.
      #1 start(0);
      @(posedge clk);
      @(negedge clk);
      chk("busy_after_trigger", 32'(busy_a), 32'd1);
      chk("lat_tvalid_c1", 32'(tvalid_a), 32'd0);
      @(negedge clk);
      chk("lat_tvalid_c2", 32'(tvalid_a), 32'd0);
      @(negedge clk);
      chk("lat_tvalid_c3", 32'(tvalid_a), 32'd1);
      cyc = 0;
      while (done_a !== 1'b1 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 3000) flag("timeout_stream1", 32'(cyc));
`ifndef RESULT_STREAM_PACK2_EN
      chk("stream_cycles", 32'(cyc), 32'(NA));
      chk("first_beat_a", first_d[0], 32'd0);
      chk("last_beat_a", last_d[0], 32'd540);
`else
      chk("first_beat_a", first_d[0], 32'h0001_0000);
      chk("last_beat_a", last_d[0], 32'h0000_021C);
`endif
      chk("beats_a_1", 32'(exp_idx[0]), 32'(nbeats(0)));

      // end_op held high: no retrigger.
      repeat (2000) @(posedge clk);
      @(negedge clk);
      chk("held_busy", 32'(busy_a), 32'd0);
      chk("held_tvalid", 32'(tvalid_a), 32'd0);
      @(posedge clk); #1 end_op_a = 1'b0;
      @(posedge clk); #1 start(0);
      wait_done(0, 3000);
      chk("beats_a_2", 32'(exp_idx[0]), 32'(nbeats(0)));
      chk("last_beat_a_2", last_d[0], exp_beat(0, nbeats(0) - 1));

      // Reset mid-transfer with end_op left high.
      @(posedge clk); #1 end_op_a = 1'b0;
      @(posedge clk); #1 start(0);
      cyc = 0;
      while (exp_idx[0] <= 100 && cyc < 1000) begin
         @(posedge clk); #3;
         cyc++;
      end
      if (cyc >= 1000) flag("timeout_beat100", 32'(cyc));
      rst = 1'b0;
      #1;
      check_zero_a("async_reset");
      active[0] = 1'b0;
      rd_exp[0] = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("post_reset_busy", 32'(busy_a), 32'd0);
      chk("post_reset_tvalid", 32'(tvalid_a), 32'd0);
      @(posedge clk); #1 end_op_a = 1'b0;
      @(posedge clk); #1 start(0);
      wait_done(0, 3000);
      chk("beats_a_3", 32'(exp_idx[0]), 32'(nbeats(0)));

      // Back-pressure from the first beat.
      mem_a[0] = CW'(2047);
      @(posedge clk); #1 end_op_a = 1'b0; tready_a = 1'b0;
      @(posedge clk); #1 start(0);
      reads = 0;
      repeat (50) begin
         @(negedge clk);
         if (en_a) reads++;
      end
      chk("stall_tvalid", 32'(tvalid_a), 32'd1);
`ifndef RESULT_STREAM_PACK2_EN
      chk("stall_tdata", tdata_a, 32'h0000_07FF);
      chk("stall_reads_le2", 32'(reads <= 2), 32'd1);
`else
      chk("stall_tdata", tdata_a, 32'h0001_07FF);
      chk("stall_reads_le4", 32'(reads <= 4), 32'd1);
`endif
      @(posedge clk); #1 tready_a = 1'b1;
      wait_done(0, 3000);
      chk("beats_a_4", 32'(exp_idx[0]), 32'(nbeats(0)));
      mem_a[0] = '0;

      // N=7 with tready pattern 1,0,0,1.
      @(posedge clk); #1 start(1);
      seen = 0;
      cyc = 0;
      while (!seen && cyc < 400) begin
         @(posedge clk); #1 tready_b = (cyc % 4 == 0) || (cyc % 4 == 3);
         cyc++;
         @(negedge clk);
         if (done_b) seen = 1;
      end
      if (!seen) flag("timeout_b_toggle", 32'(cyc));
      chk("beats_b_toggle", 32'(exp_idx[1]), 32'(nbeats(1)));
`ifndef RESULT_STREAM_PACK2_EN
      chk("last_beat_b", last_d[1], 32'd6);
`endif
      @(posedge clk); #1 tready_b = 1'b1;

`ifdef RESULT_STREAM_PACK2_EN
      for (int i = 0; i < NB; i++) mem_b[i] = CW'(i + 1);
      @(posedge clk); #1 end_op_b = 1'b0;
      @(posedge clk); #1 start(1);
      wait_done(1, 200);
      chk("pack_beat0", beats_b[0], 32'h0002_0001);
      chk("pack_beat1", beats_b[1], 32'h0004_0003);
      chk("pack_beat2", beats_b[2], 32'h0006_0005);
      chk("pack_beat3", beats_b[3], 32'h0000_0007);
      chk("pack_nbeats", 32'(exp_idx[1]), 32'd4);
`endif

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
